// File: rtl/pc_fetch_controller_pkg.sv
// Shared definitions for the PC / instruction-fetch front end.
package pc_fetch_controller_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_INC       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_controller_pc_next_mux.sv
// Priority select of the next PC: branch > jump > hold > sequential.
// Redirect targets are word-aligned by clearing bits [1:0].
module pc_fetch_controller_pc_next_mux
  import pc_fetch_controller_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_jump_target,
  input  logic              i_hold,
  input  logic [ADDR_W-1:0] i_hold_pc,
  input  logic [ADDR_W-1:0] i_seq_pc,
  output logic [ADDR_W-1:0] o_next_pc_c,
  output logic              o_redirect_c
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  always_comb begin
    o_next_pc_c  = i_seq_pc;
    o_redirect_c = 1'b0;
    if (i_branch_taken) begin
      o_next_pc_c  = i_branch_target & ALIGN_MASK;
      o_redirect_c = 1'b1;
    end else if (i_jump) begin
      o_next_pc_c  = i_jump_target & ALIGN_MASK;
      o_redirect_c = 1'b1;
    end else if (i_hold) begin
      o_next_pc_c  = i_hold_pc;
    end
  end

endmodule

// File: rtl/pc_fetch_controller.sv
// PC register and req/ack instruction-fetch sequencer for the pipeline front end.
// A request, once raised, keeps its address until acked, even across redirects.
module pc_fetch_controller
  import pc_fetch_controller_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic              flush,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_e      r_state, w_state_n;
  logic [ADDR_W-1:0] r_pc, w_pc_n;
  logic [ADDR_W-1:0] r_fetch_addr, w_fetch_addr_n;
  logic [ADDR_W-1:0] r_if_pc, w_if_pc_n;
  logic [ADDR_W-1:0] r_if_pc_plus4, w_if_pc_plus4_n;
  logic              r_req, w_req_n;
  logic              r_if_valid, w_if_valid_n;
  logic              r_flush, w_flush_n;

  logic              w_branch, w_jump, w_seq_ok, w_redirect;
  logic [ADDR_W-1:0] w_seq_pc, w_next_pc;

  // Redirects are ignored while idling out of reset.
  assign w_branch = branch_taken & (r_state != ST_IDLE);
  assign w_jump   = jump & (r_state != ST_IDLE);
  assign w_seq_ok = ((r_state == ST_FETCH) & imem_ack) | (r_state == ST_HOLD);
  assign w_seq_pc = r_fetch_addr + ADDR_W'(PC_INC);

  pc_fetch_controller_pc_next_mux #(
    .ADDR_W (ADDR_W)
  ) u_pc_next_mux (
    .i_branch_taken  (w_branch),
    .i_branch_target (branch_target),
    .i_jump          (w_jump),
    .i_jump_target   (jump_target),
    .i_hold          (stall | ~w_seq_ok),
    .i_hold_pc       (r_pc),
    .i_seq_pc        (w_seq_pc),
    .o_next_pc_c     (w_next_pc),
    .o_redirect_c    (w_redirect)
  );

  always_comb begin
    w_state_n       = r_state;
    w_pc_n          = r_pc;
    w_fetch_addr_n  = r_fetch_addr;
    w_req_n         = r_req;
    w_if_valid_n    = 1'b0;
    w_if_pc_n       = r_if_pc;
    w_if_pc_plus4_n = r_if_pc_plus4;
    w_flush_n       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_state_n      = ST_FETCH;
        w_req_n        = 1'b1;
        w_fetch_addr_n = r_pc;
      end
      ST_FETCH: begin
        w_pc_n    = w_next_pc;
        w_flush_n = w_redirect;
        if (imem_ack) begin
          if (!w_redirect && stall) begin
            w_state_n       = ST_HOLD;
            w_req_n         = 1'b0;
            w_if_valid_n    = 1'b1;
            w_if_pc_n       = r_fetch_addr;
            w_if_pc_plus4_n = w_seq_pc;
          end else begin
            w_fetch_addr_n = w_next_pc;
            w_req_n        = 1'b1;
            if (!w_redirect) begin
              w_if_valid_n    = 1'b1;
              w_if_pc_n       = r_fetch_addr;
              w_if_pc_plus4_n = w_seq_pc;
            end
          end
        end else if (w_redirect) begin
          w_state_n = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        w_pc_n    = w_next_pc;
        w_flush_n = w_redirect;
        if (w_redirect || !stall) begin
          w_state_n      = ST_FETCH;
          w_req_n        = 1'b1;
          w_fetch_addr_n = w_next_pc;
        end else begin
          w_if_valid_n = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Stale instruction is dropped on ack; the latest redirect target is fetched next.
        w_pc_n    = w_next_pc;
        w_flush_n = w_redirect;
        if (imem_ack) begin
          w_state_n      = ST_FETCH;
          w_fetch_addr_n = w_next_pc;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_req_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_fetch_addr  <= RESET_PC;
      r_req         <= 1'b0;
      r_if_valid    <= 1'b0;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
      r_flush       <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_pc          <= w_pc_n;
      r_fetch_addr  <= w_fetch_addr_n;
      r_req         <= w_req_n;
      r_if_valid    <= w_if_valid_n;
      r_if_pc       <= w_if_pc_n;
      r_if_pc_plus4 <= w_if_pc_plus4_n;
      r_flush       <= w_flush_n;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_fetch_addr;
  assign if_valid    = r_if_valid;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc_plus4;
  assign flush       = r_flush;
  assign pc          = r_pc;

endmodule
